// File: rtl/fb_rect_fill.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fb_rect_fill
// Description : Solid rectangle fill engine; clips to the framebuffer and
//               streams one registered pixel write per cycle in row-major order.
// Revision    : 1.0 - initial release
// ============================================================================
module fb_rect_fill #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic [10:0] cmd_w,
    input  logic [9:0]  cmd_h,
    input  logic [15:0] cmd_color,
    input  logic        abort,
    output logic [18:0] w_addr,
    output logic [15:0] w_data,
    output logic        we,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0]  S_IDLE     = 2'd0;
    localparam logic [1:0]  S_FILL     = 2'd1;
    localparam logic [1:0]  S_DONE     = 2'd2;
    localparam logic [11:0] c_H_RES    = 12'(H_RES);
    localparam logic [11:0] c_V_RES    = 12'(V_RES);
    localparam logic [18:0] c_ROW_STEP = 19'(H_RES);

    logic [1:0]  state_q, state_d;
    logic        rdy_q;
    logic [11:0] w_q, h_q, col_q, row_q;
    logic [18:0] row_start_q;
    logic [18:0] addr_q;
    logic [15:0] data_q;
    logic        we_q;

    logic [11:0] x_ext, y_ext, room_x, room_y, eff_w, eff_h;
    logic [18:0] first_addr;
    logic        empty, accept, last_px, row_end;

    // Widened operands keep the clip subtraction and compares overflow-free.
    assign x_ext  = {2'b00, cmd_x};
    assign y_ext  = {2'b00, cmd_y};
    assign room_x = c_H_RES - x_ext;
    assign room_y = c_V_RES - y_ext;
    assign eff_w  = ({1'b0, cmd_w} < room_x) ? {1'b0, cmd_w} : room_x;
    assign eff_h  = ({2'b00, cmd_h} < room_y) ? {2'b00, cmd_h} : room_y;
    assign empty  = (x_ext >= c_H_RES) || (y_ext >= c_V_RES) ||
                    (cmd_w == 11'd0) || (cmd_h == 10'd0);
    assign accept = cmd_valid && cmd_ready;

    // Constant multiply happens once per command; rows then step by H_RES.
    assign first_addr = (19'(cmd_y) * c_ROW_STEP) + 19'(cmd_x);

    assign row_end = (col_q == (w_q - 12'd1));
    assign last_px = row_end && (row_q == (h_q - 12'd1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = empty ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                if (abort || last_px) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == S_IDLE) && rdy_q;
        busy      = (state_q == S_FILL);
        done      = (state_q == S_DONE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q        <= 1'b0;
            addr_q      <= 19'd0;
            data_q      <= 16'd0;
            w_q         <= 12'd0;
            h_q         <= 12'd0;
            col_q       <= 12'd0;
            row_q       <= 12'd0;
            row_start_q <= 19'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && !empty) begin
                        we_q        <= 1'b1;
                        addr_q      <= first_addr;
                        row_start_q <= first_addr;
                        data_q      <= cmd_color;
                        w_q         <= eff_w;
                        h_q         <= eff_h;
                        col_q       <= 12'd0;
                        row_q       <= 12'd0;
                    end
                end
                S_FILL: begin
                    if (abort || last_px) begin
                        we_q <= 1'b0;
                    end else if (row_end) begin
                        col_q       <= 12'd0;
                        row_q       <= row_q + 12'd1;
                        row_start_q <= row_start_q + c_ROW_STEP;
                        addr_q      <= row_start_q + c_ROW_STEP;
                    end else begin
                        col_q  <= col_q + 12'd1;
                        addr_q <= addr_q + 19'd1;
                    end
                end
                default: we_q <= 1'b0;
            endcase
        end
    end

    assign w_addr = addr_q;
    assign w_data = data_q;
    assign we     = we_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_rect_fill.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fb_rect_fill
// Description : Scoreboard bench for fb_rect_fill with a geometric reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_rect_fill;

    localparam int H = 640;
    localparam int V = 480;
    localparam int SH = 16;
    localparam int SV = 12;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid, cmd_ready, abort, we, busy, done;
    logic [9:0]  cmd_x, cmd_y, cmd_h;
    logic [10:0] cmd_w;
    logic [15:0] cmd_color, w_data;
    logic [18:0] w_addr;

    logic        sm_valid, sm_ready, sm_abort, sm_we, sm_busy, sm_done;
    logic [9:0]  sm_x, sm_y, sm_h;
    logic [10:0] sm_w;
    logic [15:0] sm_color, sm_wdata;
    logic [18:0] sm_waddr;

    always #5 clk = ~clk;

    fb_rect_fill #(.H_RES(H), .V_RES(V)) u_dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_color(cmd_color), .abort(abort), .w_addr(w_addr), .w_data(w_data),
        .we(we), .busy(busy), .done(done)
    );

    fb_rect_fill #(.H_RES(SH), .V_RES(SV)) u_small (
        .clk(clk), .rstn(rstn), .cmd_valid(sm_valid), .cmd_ready(sm_ready),
        .cmd_x(sm_x), .cmd_y(sm_y), .cmd_w(sm_w), .cmd_h(sm_h),
        .cmd_color(sm_color), .abort(sm_abort), .w_addr(sm_waddr), .w_data(sm_wdata),
        .we(sm_we), .busy(sm_busy), .done(sm_done)
    );

    typedef struct {
        int cyc;
        int addr;
        int data;
    } wr_t;

    wr_t wq[$];
    int  dq[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    wr_t mon_e;
    int  sm_e = 0, sm_cnt = 0, sm_done_cnt = 0, sm_done_cyc = 0;
    bit  sm_mon = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected writes of a clipped rectangle; k>0 truncates at the k-th write.
    function automatic int model(input int e, input int x, input int y, input int w,
                                 input int h, input int color, input int k);
        int ew, eh, n;
        wr_t t;
        if (x >= H || y >= V || w == 0 || h == 0) begin
            ew = 0;
            eh = 0;
        end else begin
            ew = (w < H - x) ? w : H - x;
            eh = (h < V - y) ? h : V - y;
        end
        n = ew * eh;
        if (k > 0 && k < n) n = k;
        for (int r = 0; r < eh; r++) begin
            for (int c = 0; c < ew; c++) begin
                if (r * ew + c < n) begin
                    t.cyc  = e + r * ew + c;
                    t.addr = (y + r) * H + x + c;
                    t.data = color;
                    wq.push_back(t);
                end
            end
        end
        dq.push_back(e + n);
        return n;
    endfunction

    always @(negedge clk) begin
        if (rstn) begin
            if (we) begin
                if (wq.size() == 0) begin
                    check("unexpected_we", {13'd0, w_addr}, 32'hFFFF_FFFF);
                end else begin
                    mon_e = wq.pop_front();
                    check("wr_cycle", cyc, mon_e.cyc);
                    check("wr_addr", {13'd0, w_addr}, mon_e.addr);
                    check("wr_data", {16'd0, w_data}, mon_e.data);
                end
            end
            if (done) begin
                if (dq.size() == 0) check("unexpected_done", cyc, 32'hFFFF_FFFF);
                else check("done_cycle", cyc, dq.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rstn && sm_mon) begin
            if (sm_we) begin
                check("sm_addr", {13'd0, sm_waddr}, sm_cnt);
                check("sm_cycle", cyc, sm_e + sm_cnt);
                check("sm_data", {16'd0, sm_wdata}, 32'h0ABC);
                sm_cnt++;
            end
            if (sm_done) begin
                sm_done_cnt++;
                sm_done_cyc = cyc;
            end
        end
    end

    task automatic scramble();
        cmd_x     = 10'($urandom);
        cmd_y     = 10'($urandom);
        cmd_w     = 11'($urandom);
        cmd_h     = 10'($urandom);
        cmd_color = 16'($urandom);
    endtask

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic run_cmd(input int x, input int y, input int w, input int h,
                           input int color, input int k, input bit hold);
        int e, n;
        wait_ready();
        if (!cmd_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        e = cyc + 1;
        n = model(e, x, y, w, h, color, k);
        cmd_valid = 1'b1;
        cmd_x = x[9:0]; cmd_y = y[9:0]; cmd_w = w[10:0]; cmd_h = h[9:0];
        cmd_color = color[15:0];
        abort = hold;
        @(negedge clk);
        cmd_valid = hold;
        scramble();
        if (n > 0) begin
            check("busy_in_fill", busy, 1);
            check("ready_in_fill", cmd_ready, 0);
        end
        while (cyc < e + n) begin
            abort = (k > 0 && cyc == e + k - 1);
            @(negedge clk);
            scramble();
        end
        abort = hold;
        cmd_valid = 1'b0;
        check("ready_in_done", cmd_ready, 0);
        check("busy_in_done", busy, 0);
        @(negedge clk);
        abort = 1'b0;
        check("ready_after", cmd_ready, 1);
        check("drain_writes", wq.size(), 0);
        check("drain_done", dq.size(), 0);
    endtask

    task automatic run_small(input int w, input int h);
        int t = 0;
        @(negedge clk);
        while (!sm_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        sm_e = cyc + 1;
        sm_cnt = 0;
        sm_done_cnt = 0;
        sm_done_cyc = 0;
        sm_valid = 1'b1; sm_x = 10'd0; sm_y = 10'd0; sm_w = w[10:0]; sm_h = h[9:0];
        sm_color = 16'h0ABC;
        @(negedge clk);
        sm_valid = 1'b0;
        check("sm_busy", sm_busy, 1);
        while (cyc < sm_e + SH * SV + 2) @(negedge clk);
        check("sm_count", sm_cnt, SH * SV);
        check("sm_done_once", sm_done_cnt, 1);
        check("sm_done_cycle", sm_done_cyc, sm_e + SH * SV);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, x, y, w, h, k;
        rstn = 1'b0; cmd_valid = 1'b0; abort = 1'b0; scramble();
        sm_valid = 1'b0; sm_abort = 1'b0; sm_x = '0; sm_y = '0; sm_w = '0; sm_h = '0; sm_color = '0;
        repeat (3) @(negedge clk);
        check("rst_we", we, 0);
        check("rst_addr", {13'd0, w_addr}, 0);
        check("rst_data", {16'd0, w_data}, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_rst", cmd_ready, 1);

        run_cmd(2, 1, 3, 2, 16'h0F00, 0, 1'b0);
        run_cmd(638, 479, 5, 4, 16'h0123, 0, 1'b0);
        run_cmd(640, 0, 10, 10, 16'h0FFF, 0, 1'b0);
        run_cmd(5, 5, 0, 3, 16'h0FFF, 0, 1'b0);
        run_cmd(5, 5, 3, 0, 16'h0FFF, 0, 1'b1);
        run_cmd(0, 480, 4, 4, 16'h0FFF, 0, 1'b0);
        run_cmd(100, 200, 10, 1, 16'h00F0, 3, 1'b0);
        run_cmd(630, 10, 2047, 3, 16'h0F0F, 0, 1'b1);

        // Reset in the middle of a fill abandons it with no done pulse.
        wait_ready();
        e = cyc + 1;
        void'(model(e, 10, 10, 20, 5, 16'h0777, 0));
        cmd_valid = 1'b1; cmd_x = 10'd10; cmd_y = 10'd10; cmd_w = 11'd20; cmd_h = 10'd5;
        cmd_color = 16'h0777;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (cyc < e + 4) @(negedge clk);
        #2 rstn = 1'b0;
        wq.delete();
        dq.delete();
        #1;
        check("async_we", we, 0);
        check("async_busy", busy, 0);
        check("async_ready", cmd_ready, 0);
        repeat (2) @(negedge clk);
        check("midrst_done", done, 0);
        check("midrst_addr", {13'd0, w_addr}, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_midrst", cmd_ready, 1);
        run_cmd(7, 3, 4, 2, 16'h0321, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            x = ($urandom_range(0, 3) == 0) ? H - $urandom_range(0, 20) : $urandom_range(0, 660);
            y = ($urandom_range(0, 3) == 0) ? V - $urandom_range(0, 6) : $urandom_range(0, 490);
            w = $urandom_range(0, 40);
            h = $urandom_range(0, 8);
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            run_cmd(x, y, w, h, $urandom_range(0, 16'hFFFF), k, 1'($urandom));
        end

        sm_mon = 1'b1;
        run_small(SH, SV);
        run_small(2047, 1023);
        sm_mon = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
